// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Brief    : Control FSM for a multi-cycle CPU. States FETCH, DECODE, EXEC,
//            MEM, WB and ERR. Instruction class is captured in DECODE and
//            used by the later states.
// Options  : MULTI_CYCLE_CTRL_TIMEOUT_EN adds a memory-wait watchdog that
//            enters ERR and sets a sticky mem_err. Without it, waits are
//            unbounded and mem_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl #(
  parameter int OPC_W       = 4,
  parameter int FUNC_W      = 8,
  parameter int ALU_OP_W    = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                zero_flag,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_load,
  output logic                pc_write,
  output logic                reg_write,
  output logic                ld_window,
  output logic                alu_src_b,
  output logic                mem_to_reg,
  output logic                pc_src,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                retired,
  output logic                mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_RTYPE = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_ADDI  = 3'd4,
    C_JUMP  = 3'd5,
    C_BZ    = 3'd6,
    C_WIN   = 3'd7
  } cls_t;

  localparam logic [OPC_W-1:0] OP_R     = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BZ    = OPC_W'(5);

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d;
  logic [ALU_OP_W-1:0] aluop_q, aluop_d;

  cls_t                dec_cls;
  logic [ALU_OP_W-1:0] dec_aluop;
  logic                func_rop;
  logic                func_win;

  // Classify the instruction in IR; a lone func[i] below the top bit is ALU op i
  always_comb begin
    dec_cls   = C_NOP;
    dec_aluop = '0;
    func_rop  = 1'b0;
    for (int i = 0; i < FUNC_W-1; i++) begin
      if (func == (FUNC_W'(1) << i)) begin
        func_rop  = 1'b1;
        dec_aluop = ALU_OP_W'(i);
      end
    end
    func_win = (func == (FUNC_W'(1) << (FUNC_W-1)));
    case (opcode)
      OP_R: begin
        if (func_rop)      dec_cls = C_RTYPE;
        else if (func_win) dec_cls = C_WIN;
        else               dec_cls = C_NOP;
      end
      OP_LOAD:  dec_cls = C_LOAD;
      OP_STORE: dec_cls = C_STORE;
      OP_ADDI:  dec_cls = C_ADDI;
      OP_JUMP:  dec_cls = C_JUMP;
      OP_BZ:    dec_cls = C_BZ;
      default:  dec_cls = C_NOP;
    endcase
  end

  // Decode datapath controls from state and current inputs; rst silences all
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    ld_window     = 1'b0;
    alu_src_b     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_src        = 1'b0;
    alu_operation = '0;
    retired       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_load  = mem_ack;
          pc_write = mem_ack;
        end
        S_DECODE: begin
          case (dec_cls)
            C_JUMP: begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
              retired  = 1'b1;
            end
            C_NOP: retired = 1'b1;
            C_WIN: begin
              ld_window = 1'b1;
              retired   = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            C_RTYPE: alu_operation = aluop_q;
            C_LOAD, C_STORE, C_ADDI: alu_src_b = 1'b1;
            C_BZ: begin
              alu_operation = ALU_OP_W'(1);
              pc_write      = zero_flag;
              pc_src        = zero_flag;
              retired       = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_write = (cls_q == C_STORE);
          retired   = mem_ack && (cls_q == C_STORE);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == C_LOAD);
          retired    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q;
  logic              timeout;

  // Count unacknowledged request cycles; an ack in the limit cycle still wins
  always_comb begin
    wait_d  = '0;
    timeout = 1'b0;
    if (mem_req && !mem_ack) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) timeout = 1'b1;
      else                                    wait_d  = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      mem_err_q <= mem_err_q | timeout;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  // Next-state logic; DECODE captures the instruction class for later states
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    aluop_d = aluop_q;
    case (state_q)
      S_FETCH: if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        cls_d   = dec_cls;
        aluop_d = dec_aluop;
        case (dec_cls)
          C_JUMP, C_NOP, C_WIN: state_d = S_FETCH;
          default:              state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BZ:            state_d = S_FETCH;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: if (mem_ack) state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_FETCH;
    endcase
`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
    if (timeout) state_d = S_ERR;
`endif
  end

  // State and captured-decode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NOP;
      aluop_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      aluop_q <= aluop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Brief    : Table-driven bench for multi_cycle_ctrl plus hand-written
//            long-wait / timeout sequences (MULTI_CYCLE_CTRL_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [7:0] func;
  logic       zero_flag;
  logic       mem_ack;
  logic       mem_req, mem_write, i_or_d, ir_load, pc_write, reg_write;
  logic       ld_window, alu_src_b, mem_to_reg, pc_src, retired, mem_err;
  logic [2:0] alu_operation;

  multi_cycle_ctrl #(
    .OPC_W       (4),
    .FUNC_W      (8),
    .ALU_OP_W    (3),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .func          (func),
    .zero_flag     (zero_flag),
    .mem_ack       (mem_ack),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_load       (ir_load),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .ld_window     (ld_window),
    .alu_src_b     (alu_src_b),
    .mem_to_reg    (mem_to_reg),
    .pc_src        (pc_src),
    .alu_operation (alu_operation),
    .retired       (retired),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {alu_op[2:0], req, wr, iod, irl, pcw, rgw, ldw, srcb, m2r, pcs, ret, err}
  logic [14:0] outv;
  assign outv = {alu_operation, mem_req, mem_write, i_or_d, ir_load, pc_write,
                 reg_write, ld_window, alu_src_b, mem_to_reg, pc_src, retired, mem_err};

  localparam logic [14:0] REQ  = 15'h0800;
  localparam logic [14:0] WR   = 15'h0400;
  localparam logic [14:0] IOD  = 15'h0200;
  localparam logic [14:0] IRL  = 15'h0100;
  localparam logic [14:0] PCW  = 15'h0080;
  localparam logic [14:0] RGW  = 15'h0040;
  localparam logic [14:0] LDW  = 15'h0020;
  localparam logic [14:0] SRCB = 15'h0010;
  localparam logic [14:0] M2R  = 15'h0008;
  localparam logic [14:0] PCS  = 15'h0004;
  localparam logic [14:0] RET  = 15'h0002;
  localparam logic [14:0] ERR  = 15'h0001;
  localparam logic [14:0] FET  = REQ | IRL | PCW;

  function automatic logic [14:0] aop(input int n);
    return 15'(n) << 12;
  endfunction

  typedef struct {
    logic [79:0] nm;
    logic        r;
    logic [3:0]  opc;
    logic [7:0]  fn;
    logic        zf;
    logic        ack;
    logic [14:0] exp;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [79:0] nm, input logic r, input logic [3:0] opc,
                     input logic [7:0] fn, input logic zf, input logic ack,
                     input logic [14:0] exp);
    vec_t v;
    v.nm = nm; v.r = r; v.opc = opc; v.fn = fn; v.zf = zf; v.ack = ack; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic chk(input logic [79:0] nm, input logic [14:0] exp);
    checks++;
    if (outv !== exp) begin
      errors++;
      $display("FAIL %0s: outputs=%h expected=%h at %0t", nm, outv, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; func = '0; zero_flag = 1'b0; mem_ack = 1'b0;

    //   name          rst opc    func    zf ack expected
    add("reset",       1, 4'd0,  8'h00,  0, 0, 15'h0);
    add("fetch_wait",  0, 4'd0,  8'h00,  0, 0, REQ);
    add("r_fetch",     0, 4'd0,  8'h04,  0, 1, FET);
    add("r_decode",    0, 4'd0,  8'h04,  0, 0, 15'h0);
    add("r_exec",      0, 4'd0,  8'h04,  0, 0, aop(2));
    add("r_wb",        0, 4'd0,  8'h04,  0, 0, RGW | RET);
    add("addi_fet",    0, 4'd3,  8'h00,  0, 1, FET);
    add("addi_dec",    0, 4'd3,  8'h00,  0, 0, 15'h0);
    add("addi_exe",    0, 4'd3,  8'h00,  0, 0, SRCB);
    add("addi_wb",     0, 4'd3,  8'h00,  0, 0, RGW | RET);
    add("ld_fetch",    0, 4'd1,  8'h00,  0, 1, FET);
    add("ld_dec",      0, 4'd1,  8'h00,  0, 0, 15'h0);
    add("ld_exec",     0, 4'd1,  8'h00,  0, 0, SRCB);
    add("ld_mem1",     0, 4'd1,  8'h00,  0, 0, REQ | IOD);
    add("ld_mem2",     0, 4'd1,  8'h00,  0, 0, REQ | IOD);
    add("ld_mem3",     0, 4'd1,  8'h00,  0, 1, REQ | IOD);
    add("ld_wb",       0, 4'd1,  8'h00,  0, 0, RGW | M2R | RET);
    add("st_fetch",    0, 4'd2,  8'h00,  0, 1, FET);
    add("st_dec",      0, 4'd2,  8'h00,  0, 0, 15'h0);
    add("st_exec",     0, 4'd2,  8'h00,  0, 0, SRCB);
    add("st_mem",      0, 4'd2,  8'h00,  0, 1, REQ | WR | IOD | RET);
    add("bz1_fet",     0, 4'd5,  8'h00,  1, 1, FET);
    add("bz1_dec",     0, 4'd5,  8'h00,  1, 0, 15'h0);
    add("bz1_exe",     0, 4'd5,  8'h00,  1, 0, aop(1) | PCW | PCS | RET);
    add("bz0_fet",     0, 4'd5,  8'h00,  0, 1, FET);
    add("bz0_dec",     0, 4'd5,  8'h00,  0, 0, 15'h0);
    add("bz0_exe",     0, 4'd5,  8'h00,  0, 0, aop(1) | RET);
    add("jmp_fet",     0, 4'd4,  8'h00,  0, 1, FET);
    add("jmp_dec",     0, 4'd4,  8'h00,  0, 0, PCW | PCS | RET);
    add("nohot_fet",   0, 4'd0,  8'h06,  0, 1, FET);
    add("nohot_dec",   0, 4'd0,  8'h06,  0, 0, RET);
    add("op15_fet",    0, 4'd15, 8'h00,  0, 1, FET);
    add("op15_dec",    0, 4'd15, 8'h00,  0, 0, RET);
    add("win_fet",     0, 4'd0,  8'h80,  0, 1, FET);
    add("win_dec",     0, 4'd0,  8'h80,  0, 0, LDW | RET);
    add("ign_fet",     0, 4'd0,  8'h40,  0, 1, FET);
    add("ign_dec",     0, 4'd0,  8'h40,  0, 1, 15'h0);
    add("ign_exec",    0, 4'd0,  8'h40,  0, 1, aop(6));
    add("ign_wb",      0, 4'd0,  8'h40,  0, 1, RGW | RET);
    add("rs_fetch",    0, 4'd2,  8'h00,  0, 1, FET);
    add("rs_dec",      0, 4'd2,  8'h00,  0, 0, 15'h0);
    add("rs_exec",     0, 4'd2,  8'h00,  0, 0, SRCB);
    add("rs_memw",     0, 4'd2,  8'h00,  0, 0, REQ | WR | IOD);
    add("rs_assert",   1, 4'd2,  8'h00,  0, 0, 15'h0);
    add("rs_held",     1, 4'd2,  8'h00,  0, 0, 15'h0);
    add("rs_release",  0, 4'd4,  8'h00,  0, 0, REQ);
    add("rs_jfet",     0, 4'd4,  8'h00,  0, 1, FET);
    add("rs_jdec",     0, 4'd4,  8'h00,  0, 0, PCW | PCS | RET);

    repeat (2) @(posedge clk);
    #1;
    foreach (vq[k]) begin
      rst       = vq[k].r;
      opcode    = vq[k].opc;
      func      = vq[k].fn;
      zero_flag = vq[k].zf;
      mem_ack   = vq[k].ack;
      #1;
      chk(vq[k].nm, vq[k].exp);
      tick();
    end

    rst = 1'b0; opcode = 4'd4; func = '0; zero_flag = 1'b0; mem_ack = 1'b0;
`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
    // Fifteen unacknowledged fetch cycles trip the watchdog
    for (int i = 0; i < 15; i++) begin
      #1; chk("to_wait", REQ);
      tick();
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("to_err", ERR);
      tick();
    end
    rst = 1'b1; mem_ack = 1'b0;
    tick();
    chk("to_reset", 15'h0);
    rst = 1'b0;
    // Ack in the fifteenth wait cycle wins over the timeout
    for (int i = 0; i < 14; i++) begin
      #1; chk("lim_wait", REQ);
      tick();
    end
    mem_ack = 1'b1;
    #1; chk("lim_ack", FET);
    tick();
    mem_ack = 1'b0;
    #1; chk("lim_dec", PCW | PCS | RET);
    tick();
`else
    // Without the watchdog a long wait never errors
    for (int i = 0; i < 20; i++) begin
      #1; chk("long_wait", REQ);
      tick();
    end
    mem_ack = 1'b1;
    #1; chk("long_ack", FET);
    tick();
    mem_ack = 1'b0;
    #1; chk("long_dec", PCW | PCS | RET);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
